alu_share_arbiter: RTL and testbench

Round-robin arbiter and 2-stage sequencer that shares one combinational ALU between NREQ requesters, such as the EX-stage integer path, the branch-compare path and the address-generation path.
Each requester presents operands and a 4-bit GS op-select over a valid/ready handshake. The block registers the winning operation into the ALU input stage, captures result and flags, and returns them to the owner over a per-requester response handshake with backpressure.
It sits between the requesting pipeline units and the shared ALU instance.

---
 rtl/alu_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NREQ requesters; optional perf counters under ALU_ARB_PERF_EN.
// Latency: 2 cycles accept-to-response; 1 op/cycle sustained when responses drain.
// Backpressure: a stalled response freezes RSP and OP and drops every req_ready until the owner accepts.
module alu_share_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_gs,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_gs,
  input  logic [W-1:0]      alu_g,
  input  logic [4:0]        alu_flags,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_g,
  output logic [4:0]        rsp_flags,
  output logic [15:0]       perf_busy,
  output logic [15:0]       perf_conflict
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   gs;
  } op_t;

  logic          op_vld_q;
  logic [PW-1:0] op_owner_q;
  op_t           op_q;
  logic          rsp_vld_q;
  logic [PW-1:0] rsp_owner_q;
  logic [PW-1:0] rr_ptr_q;

  logic          rsp_fire;
  logic          rsp_free;
  logic          op_adv;
  logic          op_free;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic          accept;
  op_t           sel_op;

  assign rsp_fire = rsp_vld_q & rsp_ready[rsp_owner_q];
  assign rsp_free = ~rsp_vld_q | rsp_fire;
  assign op_adv   = op_vld_q & rsp_free;
  assign op_free  = ~op_vld_q | op_adv;

  // Cyclic scan starting just after the last winner.
  always_comb begin
    logic [PW:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!grant_vld && req_valid[idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && op_free && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_op.a  = req_a[i*W +: W];
        sel_op.b  = req_b[i*W +: W];
        sel_op.gs = req_gs[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q   <= 1'b0;
      op_owner_q <= '0;
      op_q       <= '0;
      rr_ptr_q   <= PW'(NREQ-1);
    end else begin
      if (accept) begin
        op_vld_q   <= 1'b1;
        op_owner_q <= grant_idx;
        op_q       <= sel_op;
        rr_ptr_q   <= grant_idx;
      end else if (op_adv) begin
        op_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= '0;
      rsp_g       <= '0;
      rsp_flags   <= '0;
    end else begin
      if (op_adv) begin
        rsp_vld_q   <= 1'b1;
        rsp_owner_q <= op_owner_q;
        rsp_g       <= alu_g;
        rsp_flags   <= alu_flags;
      end else if (rsp_fire) begin
        rsp_vld_q <= 1'b0;
      end
    end
  end

  assign alu_a  = op_q.a;
  assign alu_b  = op_q.b;
  assign alu_gs = op_q.gs;

  always_comb begin
    rsp_valid = '0;
    if (rsp_vld_q) begin
      rsp_valid[rsp_owner_q] = 1'b1;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [PW:0] n_valid;
  logic        conflict_ev;
  logic [15:0] busy_q;
  logic [15:0] conflict_q;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      n_valid = n_valid + (PW+1)'(req_valid[i]);
    end
  end

  assign conflict_ev = (n_valid >= (PW+1)'(2)) | ((|req_valid) & ~op_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      conflict_q <= '0;
    end else begin
      if (op_vld_q && busy_q != 16'hFFFF) begin
        busy_q <= busy_q + 16'd1;
      end
      if (conflict_ev && conflict_q != 16'hFFFF) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign perf_busy     = busy_q;
  assign perf_conflict = conflict_q;
`else
  assign perf_busy     = '0;
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a local ALU drives the result inputs, and a queue of in-flight ops predicts the outputs.
module tb_alu_share_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_gs;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [3:0]        alu_gs;
  logic [W-1:0]      alu_g;
  logic [4:0]        alu_flags;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_g;
  logic [4:0]        rsp_flags;
  logic [15:0]       perf_busy;
  logic [15:0]       perf_conflict;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_gs(req_gs),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gs(alu_gs),
    .alu_g(alu_g), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_g(rsp_g), .rsp_flags(rsp_flags),
    .perf_busy(perf_busy), .perf_conflict(perf_conflict)
  );

  always #5 clk = ~clk;

  // Returns {V,C,N,Z,L, G}.
  function automatic logic [W+4:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] gs);
    logic [W:0]   s;
    logic [W-1:0] g;
    logic         v, c;
    v = 1'b0; c = 1'b0; s = '0;
    case (gs)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        g = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (g[W-1] != a[W-1]);
      end
      4'b1000: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        g = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (g[W-1] != a[W-1]);
      end
      4'b0111: g = a & b;
      4'b0110: g = a | b;
      default: g = a ^ b;
    endcase
    return {v, c, g[W-1], (g == '0), ($signed(a) < $signed(b)), g};
  endfunction

  assign {alu_flags, alu_g} = alu_fn(alu_a, alu_b, alu_gs);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   owner;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   gs;
    bit           in_rsp;
  } ent_t;

  ent_t q[$];
  int   last;
  int   exp_busy;
  int   exp_conf;

  task automatic model_reset();
    q.delete();
    last     = NREQ - 1;
    exp_busy = 0;
    exp_conf = 0;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] gs);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_gs[i*4 +: 4] = gs;
  endtask

  task automatic rand_ops();
    logic [3:0] gs_tab [5];
    gs_tab = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0011};
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, $urandom, $urandom, gs_tab[$urandom_range(0, 4)]);
    end
  endtask

  // One clock: predict and compare outputs, then advance the model across the edge.
  task automatic cycle();
    bit              rsp_busy, fire, has_wait, op_free;
    int              grant, nv;
    logic [1:0]      idx;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic [W+4:0]    r;
    ent_t            e;
    #2;
    rsp_busy = (q.size() > 0) && q[0].in_rsp;
    fire     = rsp_busy && rsp_ready[q[0].owner];
    has_wait = (q.size() > 0) && !q[q.size()-1].in_rsp;
    op_free  = !has_wait || !rsp_busy || fire;
    grant    = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((last + k) % NREQ);
      if (grant < 0 && req_valid[idx]) grant = int'(idx);
    end
    exp_rdy = '0;
    if (op_free && grant >= 0) exp_rdy[grant] = 1'b1;
    exp_rv = '0;
    if (rsp_busy) exp_rv[q[0].owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (rsp_busy) begin
      r = alu_fn(q[0].a, q[0].b, q[0].gs);
      chk("rsp_g", 64'(rsp_g), 64'(r[W-1:0]));
      chk("rsp_flags", 64'(rsp_flags), 64'(r[W+4:W]));
    end
    if (has_wait) begin
      e = q[q.size()-1];
      chk("alu_a", 64'(alu_a), 64'(e.a));
      chk("alu_b", 64'(alu_b), 64'(e.b));
      chk("alu_gs", 64'(alu_gs), 64'(e.gs));
    end
`ifdef ALU_ARB_PERF_EN
    chk("perf_busy", 64'(perf_busy), 64'(exp_busy));
    chk("perf_conflict", 64'(perf_conflict), 64'(exp_conf));
`else
    chk("perf_busy", 64'(perf_busy), 64'd0);
    chk("perf_conflict", 64'(perf_conflict), 64'd0);
`endif
    nv = $countones(req_valid);
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (has_wait && (!rsp_busy || fire)) begin
      e = q[q.size()-1];
      e.in_rsp = 1'b1;
      q[q.size()-1] = e;
    end
    if (op_free && grant >= 0) begin
      e.owner  = 2'(grant);
      e.a      = req_a[grant*W +: W];
      e.b      = req_b[grant*W +: W];
      e.gs     = req_gs[grant*4 +: 4];
      e.in_rsp = 1'b0;
      q.push_back(e);
      last = grant;
    end
    if (has_wait) exp_busy++;
    if (nv >= 2 || (req_valid != '0 && !op_free)) exp_conf++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    req_a = '0; req_b = '0; req_gs = '0;
    model_reset();
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_gs", 64'(alu_gs), 64'd0);
    chk("rst_rsp_g", 64'(rsp_g), 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("rst_perf", 64'({perf_busy, perf_conflict}), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single op on requester 0.
    req_valid = 3'b001;
    set_op(0, 32'd5, 32'd7, 4'b0000);
    #1;
    chk("single_rdy", 64'(req_ready), 64'h1);
    cycle();
    req_valid = '0;
    cycle();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_g", 64'(rsp_g), 64'd12);
    chk("single_z", 64'(rsp_flags[1]), 64'd0);
    cycle();

    // Round-robin from a fresh reset with everyone valid.
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 4'b1000);
      #1;
      chk("rr_grant", 64'(req_ready), 64'(1 << (k % 3)));
      cycle();
    end
    req_valid = '0;
    cycle(); cycle();

    // Owner 1 stalls its response while requester 2 keeps asking.
    rsp_ready = 3'b101;
    rand_ops();
    req_valid = 3'b010;
    cycle();
    req_valid = 3'b100;
    cycle();
    rand_ops();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      cycle();
    end
    rsp_ready = 3'b111;
    #1;
    chk("bp_release", 64'(req_ready), 64'h4);
    cycle();
    req_valid = '0;
    cycle(); cycle(); cycle();

    // Flag pass-through.
    req_valid = 3'b001;
    set_op(0, 32'h8000_0000, 32'd1, 4'b1000);
    cycle();
    req_valid = '0;
    cycle();
    chk("flag_v", 64'(rsp_flags[4]), 64'd1);
    chk("flag_n", 64'(rsp_flags[2]), 64'd0);
    req_valid = 3'b001;
    set_op(0, 32'd3, 32'd3, 4'b1000);
    cycle();
    req_valid = '0;
    cycle();
    chk("flag_z", 64'(rsp_flags[1]), 64'd1);
    chk("flag_g0", 64'(rsp_g), 64'd0);
    cycle();

    // Random traffic with random response backpressure.
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    cycle(); cycle(); cycle();

    // Asynchronous reset with both stages occupied.
    req_valid = 3'b111;
    rsp_ready = 3'b000;
    rand_ops();
    cycle(); cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_alu_a", 64'(alu_a), 64'd0);
    model_reset();
    rsp_ready = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_first_grant", 64'(req_ready), 64'h1);
    cycle(); cycle(); cycle();

    // Full-rate traffic for the performance counters.
    do_reset();
    req_valid = 3'b111;
    rsp_ready = 3'b111;
    for (int k = 0; k < 11; k++) begin
      rand_ops();
      cycle();
    end
`ifdef ALU_ARB_PERF_EN
    chk("perf_busy_10", 64'(perf_busy), 64'd10);
    chk("perf_conflict_11", 64'(perf_conflict), 64'd11);
`else
    chk("perf_busy_off", 64'(perf_busy), 64'd0);
    chk("perf_conflict_off", 64'(perf_conflict), 64'd0);
`endif
    req_valid = '0;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
